// File: rtl/display_scan_controller.sv
// Four-digit seven-segment scan controller: per-slot prescaler, masked digit rotation,
// blank-first anode drive with per-digit decimal point, and a frame tick per full refresh.
module display_scan_controller #(
    parameter int unsigned CLK_DIV      = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] digit_en,
    input  logic [3:0] dp_in,
    output logic [1:0] cnt,
    output logic [3:0] an,
    output logic       dp,
    output logic       frame_tick
);

    localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);

    logic [PW-1:0] r_p;
    logic [1:0]    r_cnt;
    logic [3:0]    r_an;
    logic          r_dp;
    logic          r_tick;

    logic          w_run;
    logic          w_last;
    logic          w_lit;
    logic          w_found_hi;
    logic [1:0]    w_hi;
    logic [1:0]    w_lo;
    logic [1:0]    w_next_cnt;

    assign w_run  = en && (digit_en != 4'b0000);
    assign w_last = (r_p == P_LAST);
    assign w_lit  = en && digit_en[r_cnt] && (r_p >= P_BLANK);

    // Descending scan so the last hit is the smallest qualifying index.
    always_comb begin
        w_found_hi = 1'b0;
        w_hi       = 2'd0;
        w_lo       = r_cnt;
        for (int i = 3; i >= 0; i--) begin
            if (digit_en[i]) begin
                w_lo = 2'(i);
                if (2'(i) > r_cnt) begin
                    w_hi       = 2'(i);
                    w_found_hi = 1'b1;
                end
            end
        end
        w_next_cnt = w_found_hi ? w_hi : w_lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p    <= '0;
            r_cnt  <= 2'd0;
            r_an   <= 4'b1111;
            r_dp   <= 1'b1;
            r_tick <= 1'b0;
        end else begin
            if (!w_run || w_last) begin
                r_p <= '0;
            end else begin
                r_p <= r_p + PW'(1);
            end
            if (w_run && w_last) begin
                r_cnt <= w_next_cnt;
            end
            r_tick <= w_run && w_last && (w_next_cnt <= r_cnt);
            r_an   <= w_lit ? ~(4'b0001 << r_cnt) : 4'b1111;
            r_dp   <= w_lit ? ~dp_in[r_cnt] : 1'b1;
        end
    end

    assign cnt        = r_cnt;
    assign an         = r_an;
    assign dp         = r_dp;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller (CLK_DIV = 8, BLANK_CYCLES = 2): stimulus pushes
// predicted outputs per cycle, a monitor pops and compares on the falling edge.
module tb_display_scan_controller;

    localparam int unsigned DIV = 8;
    localparam int unsigned BLK = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] digit_en;
    logic [3:0] dp_in;
    logic [1:0] cnt;
    logic [3:0] an;
    logic       dp;
    logic       frame_tick;

    display_scan_controller #(
        .CLK_DIV     (DIV),
        .BLANK_CYCLES(BLK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .digit_en  (digit_en),
        .dp_in     (dp_in),
        .cnt       (cnt),
        .an        (an),
        .dp        (dp),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cnt;
        logic [3:0] an;
        logic       dp;
        logic       tick;
        int         sc;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    event e_chk;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   scen     = 0;
    int   cyc      = 0;

    // Reference model state, describing DUT registers after each clock edge.
    int         m_p;
    int         m_cnt;
    logic [3:0] m_an;
    logic       m_dp;
    logic       m_tick;

    function automatic int next_idx(input int cur, input logic [3:0] mask);
        int r;
        r = cur;
        for (int k = 1; k <= 4; k++) begin
            if (mask[(cur + k) % 4]) begin
                r = (cur + k) % 4;
                break;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_p    = 0;
        m_cnt  = 0;
        m_an   = 4'b1111;
        m_dp   = 1'b1;
        m_tick = 1'b0;
    endtask

    task automatic model_edge();
        bit lit;
        int nxt;
        if (!rst_n) begin
            model_reset();
        end else begin
            lit    = en && digit_en[m_cnt] && (m_p >= BLK);
            m_an   = lit ? ~(4'b0001 << m_cnt) : 4'b1111;
            m_dp   = lit ? ~dp_in[m_cnt] : 1'b1;
            m_tick = 1'b0;
            if (en && (digit_en != 4'b0000)) begin
                if (m_p == DIV - 1) begin
                    nxt    = next_idx(m_cnt, digit_en);
                    m_tick = (nxt <= m_cnt);
                    m_cnt  = nxt;
                    m_p    = 0;
                end else begin
                    m_p = m_p + 1;
                end
            end else begin
                m_p = 0;
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.cnt  = 2'(m_cnt);
        e.an   = m_an;
        e.dp   = m_dp;
        e.tick = m_tick;
        e.sc   = scen;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            cyc++;
            #1;
            push_exp();
        end
    endtask

    // Monitor: compare on the falling edge, or on demand for the asynchronous reset check.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or e_chk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({cnt, an, dp, frame_tick} === {e.cnt, e.an, e.dp, e.tick}) begin
                    n_pass++;
                end else begin
                    $display("FAIL sc%0d cyc%0d got cnt=%0d an=%b dp=%b tick=%b exp cnt=%0d an=%b dp=%b tick=%b",
                             e.sc, e.cyc, cnt, an, dp, frame_tick, e.cnt, e.an, e.dp, e.tick);
                end
            end
        end
    end

    initial begin
        int guard;
        rst_n    = 1'b0;
        en       = 1'b1;
        digit_en = 4'b1111;
        dp_in    = 4'b0000;
        model_reset();

        // Reset state, then release and run two full frames with all digits.
        scen = 1;
        step(2);
        rst_n = 1'b1;
        step(70);

        scen = 2;
        digit_en = 4'b1010;
        step(40);

        scen = 3;
        digit_en = 4'b0100;
        step(24);

        scen = 4;
        digit_en = 4'b1111;
        dp_in    = 4'b0010;
        step(40);

        // Drop enable at p = 5 with cnt = 2, then resume.
        scen  = 5;
        dp_in = 4'b0000;
        guard = 0;
        while (!(m_cnt == 2 && m_p == 5) && guard < 64) begin
            step(1);
            guard++;
        end
        if (guard >= 64) begin
            n_checks++;
            $display("FAIL en_drop_setup got guard=%0d exp <64", guard);
        end
        en = 1'b0;
        step(5);
        en = 1'b1;
        step(12);

        scen = 6;
        digit_en = 4'b0000;
        step(12);
        digit_en = 4'b1111;
        step(20);

        // Asynchronous reset while digit 0 is lit; checked before the next rising edge.
        scen  = 7;
        guard = 0;
        while (m_an != 4'b1110 && guard < 64) begin
            step(1);
            guard++;
        end
        if (guard >= 64) begin
            n_checks++;
            $display("FAIL rst_setup got guard=%0d exp <64", guard);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        push_exp();
        -> e_chk;
        #1;
        step(2);
        rst_n = 1'b1;
        step(40);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL queue_drain got %0d entries exp 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
